// File: rtl/os_tx_generator_pkg.sv
// Shared definitions for the Gen1/Gen2 transmit ordered-set generator.
// Holds the 8b/10b symbol constants, the os_type encodings (shared with the
// TX LTSSM), set lengths and the latched training-set field bundle.
// Optional feature macro: OS_TX_EIEOS_EN (enables os_type 4, EIEOS).
package os_tx_generator_pkg;

    localparam logic [7:0] SymCom   = 8'hBC;  // K28.5
    localparam logic [7:0] SymPad   = 8'hF7;  // K23.7
    localparam logic [7:0] SymSkp   = 8'h1C;  // K28.0
    localparam logic [7:0] SymIdl   = 8'h7C;  // K28.3
    localparam logic [7:0] SymEie   = 8'hFC;  // K28.7
    localparam logic [7:0] SymTs1Id = 8'h4A;  // D10.2
    localparam logic [7:0] SymTs2Id = 8'h45;  // D5.2

    localparam int unsigned LongSetLen  = 16;
    localparam int unsigned ShortSetLen = 4;

    typedef enum logic [2:0] {
        OsTs1   = 3'd0,
        OsTs2   = 3'd1,
        OsSkp   = 3'd2,
        OsEios  = 3'd3,
        OsEieos = 3'd4
    } os_type_e;

    typedef struct packed {
        logic [7:0] link_number;
        logic       link_pad;
        logic       lane_pad;
        logic [7:0] n_fts;
        logic [7:0] rate_id;
        logic [7:0] train_ctl;
    } ts_fields_t;

    // Index of the final symbol of a set of the given type.
    function automatic logic [3:0] os_last_idx(os_type_e t);
        case (t)
            OsSkp, OsEios: return 4'(ShortSetLen - 1);
            default:       return 4'(LongSetLen - 1);
        endcase
    endfunction

    function automatic logic os_type_supported(logic [2:0] t);
`ifdef OS_TX_EIEOS_EN
        return t <= 3'd4;
`else
        return t <= 3'd3;
`endif
    endfunction

endpackage

// File: rtl/os_tx_generator_rom.sv
// os_symbol_rom: combinational per-lane symbol lookup.
// Ports:
//   os_type_i  - ordered-set type being sent
//   sym_idx_i  - symbol position within the set
//   fields_i   - latched TS fields (link/lane pad, n_fts, rate_id, train_ctl)
//   lane_idx_i - this lane's number, sent as TS symbol 2
//   sym_o      - symbol byte
//   symk_o     - K flag
// Optional feature macro: OS_TX_EIEOS_EN (adds the EIEOS pattern).
module os_symbol_rom
    import os_tx_generator_pkg::*;
(
    input  os_type_e   os_type_i,
    input  logic [3:0] sym_idx_i,
    input  ts_fields_t fields_i,
    input  logic [7:0] lane_idx_i,
    output logic [7:0] sym_o,
    output logic       symk_o
);

    always_comb begin
        sym_o  = 8'h00;
        symk_o = 1'b0;
        case (os_type_i)
            OsTs1, OsTs2: begin
                case (sym_idx_i)
                    4'd0: begin
                        sym_o  = SymCom;
                        symk_o = 1'b1;
                    end
                    4'd1: begin
                        sym_o  = fields_i.link_pad ? SymPad : fields_i.link_number;
                        symk_o = fields_i.link_pad;
                    end
                    4'd2: begin
                        sym_o  = fields_i.lane_pad ? SymPad : lane_idx_i;
                        symk_o = fields_i.lane_pad;
                    end
                    4'd3:    sym_o = fields_i.n_fts;
                    4'd4:    sym_o = fields_i.rate_id;
                    4'd5:    sym_o = fields_i.train_ctl;
                    default: sym_o = (os_type_i == OsTs1) ? SymTs1Id : SymTs2Id;
                endcase
            end
            OsSkp: begin
                sym_o  = (sym_idx_i == 4'd0) ? SymCom : SymSkp;
                symk_o = 1'b1;
            end
            OsEios: begin
                sym_o  = (sym_idx_i == 4'd0) ? SymCom : SymIdl;
                symk_o = 1'b1;
            end
`ifdef OS_TX_EIEOS_EN
            OsEieos: begin
                if (sym_idx_i == 4'd0) begin
                    sym_o  = SymCom;
                    symk_o = 1'b1;
                end else if (sym_idx_i == 4'd15) begin
                    sym_o  = SymTs1Id;
                    symk_o = 1'b0;
                end else begin
                    sym_o  = SymEie;
                    symk_o = 1'b1;
                end
            end
`endif
            default: begin
                sym_o  = 8'h00;
                symk_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/os_tx_generator.sv
// os_tx_generator: transmit-side ordered-set generator (Gen1/Gen2, 8b/10b).
// Emits TS1/TS2/SKP/EIOS (and EIEOS when OS_TX_EIEOS_EN is defined) one
// symbol per lane per clock. The FSM registers drive the per-lane symbol
// ROMs, and every output is registered behind them, so the first symbol
// appears one edge after the accepting edge.
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   os_req_i          - request, accepted when os_req_i && os_ready_o
//   os_type_i         - 0 TS1, 1 TS2, 2 SKP, 3 EIOS, 4 EIEOS
//   os_count_i        - sets to send back to back (0 means 1)
//   link_number_i, link_pad_i, lane_pad_i, n_fts_i, rate_id_i, train_ctl_i
//                     - TS fields, latched on accept
//   os_abort_i        - finish the current set, then stop
//   tx_data_o         - lane i symbol at [8i+:8]
//   tx_datak_o        - per-lane K flag
//   tx_valid_o        - data valid
//   os_ready_o        - idle, may accept
//   os_done_o         - pulse on the final symbol of the final set
// Optional feature macro: OS_TX_EIEOS_EN.
module os_tx_generator
    import os_tx_generator_pkg::*;
#(
    parameter int unsigned LANES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               os_req_i,
    input  logic [2:0]         os_type_i,
    input  logic [7:0]         os_count_i,
    input  logic [7:0]         link_number_i,
    input  logic               link_pad_i,
    input  logic               lane_pad_i,
    input  logic [7:0]         n_fts_i,
    input  logic [7:0]         rate_id_i,
    input  logic [7:0]         train_ctl_i,
    input  logic               os_abort_i,
    output logic [8*LANES-1:0] tx_data_o,
    output logic [LANES-1:0]   tx_datak_o,
    output logic               tx_valid_o,
    output logic               os_ready_o,
    output logic               os_done_o
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e     state_q, state_d;
    os_type_e   type_q, type_d;
    ts_fields_t fields_q, fields_d;
    logic [3:0] sym_idx_q, sym_idx_d;
    logic [7:0] remaining_q, remaining_d;
    logic       abort_q, abort_d;

    logic [8*LANES-1:0] tx_data_q, tx_data_d;
    logic [LANES-1:0]   tx_datak_q, tx_datak_d;
    logic               tx_valid_q, tx_valid_d;
    logic               os_ready_q, os_ready_d;
    logic               os_done_q, os_done_d;

    logic [8*LANES-1:0] rom_data;
    logic [LANES-1:0]   rom_k;
    logic               accept;
    logic               last_sym;
    logic               final_set;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        os_symbol_rom u_rom (
            .os_type_i (type_q),
            .sym_idx_i (sym_idx_q),
            .fields_i  (fields_q),
            .lane_idx_i(8'(i)),
            .sym_o     (rom_data[8*i +: 8]),
            .symk_o    (rom_k[i])
        );
    end

    always_comb begin
        accept    = os_req_i && os_ready_q && os_type_supported(os_type_i);
        last_sym  = (sym_idx_q == os_last_idx(type_q));
        // An abort seen on the last symbol itself still ends here, with one os_done.
        final_set = last_sym && ((remaining_q == 8'd1) || abort_q || os_abort_i);

        state_d     = state_q;
        type_d      = type_q;
        fields_d    = fields_q;
        sym_idx_d   = sym_idx_q;
        remaining_d = remaining_q;
        abort_d     = abort_q;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d              = StSend;
                    type_d               = os_type_e'(os_type_i);
                    fields_d.link_number = link_number_i;
                    fields_d.link_pad    = link_pad_i;
                    fields_d.lane_pad    = lane_pad_i;
                    fields_d.n_fts       = n_fts_i;
                    fields_d.rate_id     = rate_id_i;
                    fields_d.train_ctl   = train_ctl_i;
                    sym_idx_d            = 4'd0;
                    remaining_d          = (os_count_i == 8'd0) ? 8'd1 : os_count_i;
                    abort_d              = 1'b0;
                end
            end
            StSend: begin
                abort_d = abort_q || os_abort_i;
                if (last_sym) begin
                    sym_idx_d   = 4'd0;
                    remaining_d = remaining_q - 8'd1;
                    if (final_set) begin
                        state_d = StIdle;
                        abort_d = 1'b0;
                    end
                end else begin
                    sym_idx_d = sym_idx_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Output stage: reflects the symbol selected by the current FSM registers.
        tx_valid_d = (state_q == StSend);
        tx_data_d  = (state_q == StSend) ? rom_data : '0;
        tx_datak_d = (state_q == StSend) ? rom_k : '0;
        os_done_d  = (state_q == StSend) && final_set;
        // Ready drops on the accepting edge so a second request cannot slip in.
        os_ready_d = (state_q == StIdle) && !accept;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            type_q      <= OsTs1;
            fields_q    <= '0;
            sym_idx_q   <= 4'd0;
            remaining_q <= 8'd0;
            abort_q     <= 1'b0;
            tx_data_q   <= '0;
            tx_datak_q  <= '0;
            tx_valid_q  <= 1'b0;
            os_ready_q  <= 1'b1;
            os_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            fields_q    <= fields_d;
            sym_idx_q   <= sym_idx_d;
            remaining_q <= remaining_d;
            abort_q     <= abort_d;
            tx_data_q   <= tx_data_d;
            tx_datak_q  <= tx_datak_d;
            tx_valid_q  <= tx_valid_d;
            os_ready_q  <= os_ready_d;
            os_done_q   <= os_done_d;
        end
    end

    assign tx_data_o  = tx_data_q;
    assign tx_datak_o = tx_datak_q;
    assign tx_valid_o = tx_valid_q;
    assign os_ready_o = os_ready_q;
    assign os_done_o  = os_done_q;

endmodule

// File: tb/tb_os_tx_generator.sv
// Scoreboard bench for os_tx_generator: stimulus pushes expected symbols per
// valid cycle into a queue; a negedge monitor pops and compares.
module tb_os_tx_generator;

    localparam int LANES = 16;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                os_req = 1'b0;
    logic [2:0]          os_type = 3'd0;
    logic [7:0]          os_count = 8'd0;
    logic [7:0]          link_number = 8'd0;
    logic                link_pad = 1'b0;
    logic                lane_pad = 1'b0;
    logic [7:0]          n_fts = 8'd0;
    logic [7:0]          rate_id = 8'd0;
    logic [7:0]          train_ctl = 8'd0;
    logic                os_abort = 1'b0;
    logic [8*LANES-1:0]  tx_data;
    logic [LANES-1:0]    tx_datak;
    logic                tx_valid;
    logic                os_ready;
    logic                os_done;

    os_tx_generator #(.LANES(LANES)) dut (
        .clk          (clk),
        .reset        (reset),
        .os_req_i     (os_req),
        .os_type_i    (os_type),
        .os_count_i   (os_count),
        .link_number_i(link_number),
        .link_pad_i   (link_pad),
        .lane_pad_i   (lane_pad),
        .n_fts_i      (n_fts),
        .rate_id_i    (rate_id),
        .train_ctl_i  (train_ctl),
        .os_abort_i   (os_abort),
        .tx_data_o    (tx_data),
        .tx_datak_o   (tx_datak),
        .tx_valid_o   (tx_valid),
        .os_ready_o   (os_ready),
        .os_done_o    (os_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8*LANES-1:0] d;
        logic [LANES-1:0]   k;
        logic               done;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    logic prev_open = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-written symbol tables for each ordered set, expanded over lanes.
    task automatic push_os(input int t, input int sets, input logic [7:0] link, input logic lpad,
                           input logic lnpad, input logic [7:0] nf, input logic [7:0] rt,
                           input logic [7:0] ctl);
        int len;
        exp_t e;
        logic [7:0] s;
        logic kk;
        len = (t == 2 || t == 3) ? 4 : 16;
        for (int st = 0; st < sets; st++) begin
            for (int j = 0; j < len; j++) begin
                e.d = '0;
                e.k = '0;
                for (int l = 0; l < LANES; l++) begin
                    s = 8'h00;
                    kk = 1'b0;
                    if (t == 0 || t == 1) begin
                        case (j)
                            0: begin s = 8'hBC; kk = 1'b1; end
                            1: begin s = lpad ? 8'hF7 : link; kk = lpad; end
                            2: begin s = lnpad ? 8'hF7 : 8'(l); kk = lnpad; end
                            3: s = nf;
                            4: s = rt;
                            5: s = ctl;
                            default: s = (t == 0) ? 8'h4A : 8'h45;
                        endcase
                    end else if (t == 2) begin
                        s = (j == 0) ? 8'hBC : 8'h1C; kk = 1'b1;
                    end else if (t == 3) begin
                        s = (j == 0) ? 8'hBC : 8'h7C; kk = 1'b1;
                    end else begin
                        s = (j == 0) ? 8'hBC : (j == 15) ? 8'h4A : 8'hFC;
                        kk = (j != 15);
                    end
                    e.d[8*l +: 8] = s;
                    e.k[l] = kk;
                end
                e.done = (st == sets - 1) && (j == len - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    // Waits for ready, presents one request for one edge, then scrambles the
    // field inputs to show the latched copy is used.
    task automatic issue(input int t, input logic [7:0] cnt, input int exp_sets,
                         input logic [7:0] link, input logic lpad, input logic lnpad,
                         input logic [7:0] nf, input logic [7:0] rt, input logic [7:0] ctl);
        int n = 0;
        while (!os_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) check("ready_timeout", {127'b0, os_ready}, 128'd1);
        push_os(t, exp_sets, link, lpad, lnpad, nf, rt, ctl);
        os_req = 1'b1; os_type = 3'(t); os_count = cnt;
        link_number = link; link_pad = lpad; lane_pad = lnpad;
        n_fts = nf; rate_id = rt; train_ctl = ctl;
        @(posedge clk); #1;
        os_req = 1'b0;
        check("ready_low_after_accept", {127'b0, os_ready}, 128'd0);
        link_number = 8'hEE; link_pad = ~lpad; lane_pad = ~lnpad;
        n_fts = 8'hDD; rate_id = 8'hCC; train_ctl = 8'hBB; os_type = 3'd3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && os_ready) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 300) check("idle_timeout", {exp_q.size(), os_ready}, {32'd0, 1'b1});
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic drop_check(input logic [2:0] t);
        os_req = 1'b1; os_type = t;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("unsupported_ready", {127'b0, os_ready}, 128'd1);
            check("unsupported_valid", {127'b0, tx_valid}, 128'd0);
        end
        os_req = 1'b0;
    endtask

    // Monitor.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            prev_open = 1'b0;
        end else begin
            if (prev_open) check("contiguous", {127'b0, tx_valid}, 128'd1);
            if (tx_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", {127'b0, tx_valid}, 128'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_data", tx_data, e.d);
                    check("tx_datak", {112'b0, tx_datak}, {112'b0, e.k});
                    check("os_done", {127'b0, os_done}, {127'b0, e.done});
                end
            end else begin
                check("idle_done", {127'b0, os_done}, 128'd0);
                check("idle_data", {tx_data | 128'(tx_datak)}, 128'd0);
            end
            prev_open = tx_valid && !os_done;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_ready", {127'b0, os_ready}, 128'd1);
        check("rst_valid", {127'b0, tx_valid}, 128'd0);
        check("rst_done", {127'b0, os_done}, 128'd0);
        check("rst_data", tx_data, 128'd0);
        check("rst_datak", {112'b0, tx_datak}, 128'd0);

        // TS1, two sets.
        issue(0, 8'd2, 2, 8'h05, 1'b0, 1'b0, 8'h20, 8'h02, 8'h00);
        wait_idle();
        // TS2 with link and lane PAD.
        issue(1, 8'd1, 1, 8'h11, 1'b1, 1'b1, 8'h1F, 8'h02, 8'h08);
        wait_idle();
        // SKP with count 0 -> one set, then EIOS.
        issue(2, 8'd0, 1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_idle();
        issue(3, 8'd1, 1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_idle();

        // Abort at symbol 7 of set 3 (global output index 39).
        issue(0, 8'd100, 3, 8'h01, 1'b0, 1'b0, 8'h10, 8'h02, 8'h00);
        repeat (40) @(posedge clk);
        #1 os_abort = 1'b1;
        @(posedge clk);
        #1 os_abort = 1'b0;
        wait_idle();

        // Reset while symbol 9 is on the outputs.
        issue(0, 8'd1, 1, 8'h07, 1'b0, 1'b0, 8'h20, 8'h02, 8'h00);
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        exp_q.delete();
        #1;
        check("async_rst_valid", {127'b0, tx_valid}, 128'd0);
        check("async_rst_data", tx_data, 128'd0);
        check("async_rst_datak", {112'b0, tx_datak}, 128'd0);
        check("async_rst_ready", {127'b0, os_ready}, 128'd1);
        check("async_rst_done", {127'b0, os_done}, 128'd0);
        @(posedge clk); @(posedge clk);
        #1 reset = 1'b0;
        issue(2, 8'd2, 2, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_idle();

`ifdef OS_TX_EIEOS_EN
        issue(4, 8'd1, 1, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        wait_idle();
`else
        drop_check(3'd4);
        wait_idle();
`endif
        drop_check(3'd5);
        wait_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
